// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit XNOR LFSR generator and its receive-side checker.
package lfsr_pkg;

  localparam int LFSR_W      = 8;
  localparam int LFSR_TAP_HI = 7;
  localparam int LFSR_TAP_LO = 3;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 8'hFF;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // XNOR feedback; all-ones maps onto itself, so it is a legal step.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ~(v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO])};
  endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; clear takes priority over increment.
module lfsr_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: clear wins, then increment until all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR stream: lock, mismatch and lockup detection.
// Optional error counter built only when LFSR_CHECKER_ERR_CNT_EN is defined.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic              lockup,
  output logic [CNT_W-1:0]  err_count
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);
  localparam logic [GW-1:0] LOCK_V   = GW'(LOCK_CNT);
  localparam logic [BW-1:0] UNLOCK_V = BW'(UNLOCK_CNT);

  chk_state_t        state_r, state_s;
  logic [LFSR_W-1:0] prev_r;
  logic              prev_valid_r;
  logic [GW-1:0]     good_run_r, good_run_s, good_inc_s;
  logic [BW-1:0]     bad_run_r, bad_run_s, bad_inc_s;
  logic              err_r, err_s;
  logic              lockup_r, lockup_s;
  logic              match_s;

  // Next-state, run counters, mismatch pulse and lockup flag.
  always_comb begin
    state_s    = state_r;
    good_run_s = good_run_r;
    bad_run_s  = bad_run_r;
    err_s      = 1'b0;
    lockup_s   = lockup_r;
    match_s    = (in_data == lfsr_next(prev_r));
    good_inc_s = good_run_r + {{(GW-1){1'b0}}, 1'b1};
    bad_inc_s  = bad_run_r + {{(BW-1){1'b0}}, 1'b1};
    if (in_valid) begin
      if (in_data != LFSR_LOCKUP) begin
        lockup_s = 1'b0;
      end else if (prev_valid_r && (prev_r == LFSR_LOCKUP)) begin
        lockup_s = 1'b1;
      end else begin
        lockup_s = lockup_r;
      end
      if (prev_valid_r) begin
        case (state_r)
          HUNT: begin
            if (!match_s) begin
              good_run_s = '0;
            end else if (good_inc_s == LOCK_V) begin
              good_run_s = good_inc_s;
              bad_run_s  = '0;
              state_s    = LOCKED;
            end else begin
              good_run_s = good_inc_s;
            end
          end
          LOCKED: begin
            if (match_s) begin
              bad_run_s = '0;
            end else begin
              err_s     = 1'b1;
              bad_run_s = bad_inc_s;
              if (bad_inc_s == UNLOCK_V) begin
                state_s    = HUNT;
                good_run_s = '0;
              end else begin
                state_s    = LOCKED;
              end
            end
          end
          default: begin
            state_s    = HUNT;
            good_run_s = '0;
            bad_run_s  = '0;
          end
        endcase
      end else begin
        state_s = state_r;
      end
    end else begin
      lockup_s = lockup_r;
    end
  end

  // State and output registers; idle cycles hold everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= HUNT;
      prev_r       <= '0;
      prev_valid_r <= 1'b0;
      good_run_r   <= '0;
      bad_run_r    <= '0;
      err_r        <= 1'b0;
      lockup_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      good_run_r   <= good_run_s;
      bad_run_r    <= bad_run_s;
      err_r        <= err_s;
      lockup_r     <= lockup_s;
      if (in_valid) begin
        prev_r       <= in_data;
        prev_valid_r <= 1'b1;
      end else begin
        prev_r       <= prev_r;
        prev_valid_r <= prev_valid_r;
      end
    end
  end

  assign locked = (state_r == LOCKED);
  assign err    = err_r;
  assign lockup = lockup_r;

`ifdef LFSR_CHECKER_ERR_CNT_EN
  lfsr_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_s),
    .clr   (clear),
    .count (err_count)
  );
`else
  logic unused_clear_s;
  assign unused_clear_s = clear;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed self-checking bench for lfsr_checker; a second instance exercises counter saturation.
module tb_lfsr_checker;

`ifdef LFSR_CHECKER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        clear = 1'b0;
  logic        locked, err, lockup;
  logic [15:0] err_count;

  logic        sat_valid = 1'b0;
  logic [7:0]  sat_data = 8'h00;
  logic        sat_locked, sat_err, sat_lockup;
  logic [3:0]  sat_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .clear(clear),
    .locked(locked), .err(err), .lockup(lockup), .err_count(err_count)
  );

  lfsr_checker #(.LOCK_CNT(4), .UNLOCK_CNT(200), .CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(sat_valid), .in_data(sat_data), .clear(1'b0),
    .locked(sat_locked), .err(sat_err), .lockup(sat_lockup), .err_count(sat_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // One cycle on the main DUT; outputs are settled when the task returns.
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic sat_step(input logic [7:0] d);
    @(negedge clk);
    sat_valid = 1'b1;
    sat_data  = d;
    @(posedge clk);
    #1;
    sat_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // 00,01,03,07,0F: four matching transitions after the loading sample.
  task automatic lock_seq();
    logic [7:0] seq [5];
    seq = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
  endtask

  initial begin
    logic [7:0] gap [4];
    int err_seen;

    #1;
    check_eq("reset_locked", {31'd0, locked}, 32'd0);
    check_eq("reset_err", {31'd0, err}, 32'd0);
    check_eq("reset_lockup", {31'd0, lockup}, 32'd0);
    check_eq("reset_count", {16'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Lock: not locked after 4 samples, locked after the 5th.
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    check_eq("lock_early", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h0F, 1'b0);
    check_eq("lock_rise", {31'd0, locked}, 32'd1);
    check_eq("lock_err", {31'd0, err}, 32'd0);
    check_eq("lock_count", {16'd0, err_count}, 32'd0);

    // Error and unlock: 1E matches, 55 and 3C mismatch.
    step(1'b1, 8'h1E, 1'b0);
    check_eq("e1_err", {31'd0, err}, 32'd0);
    step(1'b1, 8'h55, 1'b0);
    check_eq("e2_err", {31'd0, err}, 32'd1);
    check_eq("e2_count", {16'd0, err_count}, exp_cnt(1));
    check_eq("e2_locked", {31'd0, locked}, 32'd1);
    step(1'b1, 8'h3C, 1'b0);
    check_eq("e3_err", {31'd0, err}, 32'd1);
    check_eq("e3_count", {16'd0, err_count}, exp_cnt(2));
    check_eq("e3_locked", {31'd0, locked}, 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check_eq("e4_err_pulse", {31'd0, err}, 32'd0);

    // Gaps: three idle cycles between each locked sample are transparent.
    do_reset();
    lock_seq();
    gap = '{8'h1E, 8'h3C, 8'h78, 8'hF0};
    err_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, gap[i], 1'b0);
      if (err) err_seen++;
      for (int j = 0; j < 3; j++) begin
        step(1'b0, 8'hA5, 1'b0);
        if (err) err_seen++;
      end
    end
    check_eq("gap_locked", {31'd0, locked}, 32'd1);
    check_eq("gap_err", 32'(err_seen), 32'd0);
    step(1'b1, 8'hE0, 1'b0);
    check_eq("gap_next_err", {31'd0, err}, 32'd0);

    // Lockup in HUNT.
    do_reset();
    step(1'b1, 8'hFF, 1'b0);
    check_eq("lk1_lockup", {31'd0, lockup}, 32'd0);
    step(1'b1, 8'hFF, 1'b0);
    check_eq("lk2_lockup", {31'd0, lockup}, 32'd1);
    check_eq("lk2_err", {31'd0, err}, 32'd0);
    step(1'b1, 8'h00, 1'b0);
    check_eq("lk3_lockup", {31'd0, lockup}, 32'd0);

    // Stuck FF stream locks and never flags err.
    do_reset();
    err_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      if (err) err_seen++;
    end
    check_eq("ffs_locked", {31'd0, locked}, 32'd1);
    check_eq("ffs_lockup", {31'd0, lockup}, 32'd1);
    check_eq("ffs_err", 32'(err_seen), 32'd0);

    // Clear collides with a locked mismatch: clear wins.
    do_reset();
    lock_seq();
    step(1'b1, 8'h55, 1'b0);
    check_eq("clr_pre_count", {16'd0, err_count}, exp_cnt(1));
    step(1'b1, 8'hAB, 1'b0);
    check_eq("clr_match_err", {31'd0, err}, 32'd0);
    step(1'b1, 8'h00, 1'b1);
    check_eq("clr_err", {31'd0, err}, 32'd1);
    check_eq("clr_count", {16'd0, err_count}, 32'd0);
    check_eq("clr_locked", {31'd0, locked}, 32'd1);

    // Build err_count=2 while staying locked, then reset mid-cycle.
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h00, 1'b0);
    check_eq("rm_pre_count", {16'd0, err_count}, exp_cnt(2));
    check_eq("rm_pre_locked", {31'd0, locked}, 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("rm_locked", {31'd0, locked}, 32'd0);
    check_eq("rm_count", {16'd0, err_count}, 32'd0);
    check_eq("rm_lockup", {31'd0, lockup}, 32'd0);
    check_eq("rm_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h03, 1'b0);
    step(1'b1, 8'h07, 1'b0);
    check_eq("rm_relock_early", {31'd0, locked}, 32'd0);
    step(1'b1, 8'h0F, 1'b0);
    check_eq("rm_relock", {31'd0, locked}, 32'd1);

    // Saturation on the 4-bit counter instance: 20 mismatches, counter stops at F.
    sat_step(8'h00);
    sat_step(8'h01);
    sat_step(8'h03);
    sat_step(8'h07);
    sat_step(8'h0F);
    check_eq("sat_locked0", {31'd0, sat_locked}, 32'd1);
    err_seen = 0;
    for (int i = 0; i < 20; i++) begin
      sat_step(8'h00);
      if (sat_err) err_seen++;
    end
    check_eq("sat_pulses", 32'(err_seen), 32'd20);
    check_eq("sat_count", {28'd0, sat_count}, CNT_EN ? 32'hF : 32'd0);
    check_eq("sat_locked", {31'd0, sat_locked}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
